// File: rtl/ledscan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered display image.
// Optional leading-zero suppression is enabled by defining LEDSCAN_LZS_EN.
module ledscan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int INTERVAL = 799999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  input  logic [DIGITS-1:0]     wr_blank,
  output logic                  wr_ready,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int CW = $clog2(INTERVAL + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(INTERVAL);
  localparam logic [IW-1:0] IDX_TOP  = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  pending;
  logic [4*DIGITS-1:0]   sh_data, act_data;
  logic [DIGITS-1:0]     sh_dp, act_dp;
  logic [DIGITS-1:0]     sh_blank, act_blank;

  logic wrap, boundary, accept;

  assign wrap     = (cnt == CNT_LAST);
  assign boundary = wrap && (idx == '0);
  assign accept   = wr_en && !pending;
  assign wr_ready = ~pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= IDX_TOP;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      cnt        <= wrap ? '0 : cnt + 1'b1;
      frame_done <= boundary;
      if (wrap)
        idx <= (idx == '0) ? IDX_TOP : idx - 1'b1;
      if (accept) begin
        sh_data  <= wr_data;
        sh_dp    <= wr_dp;
        sh_blank <= wr_blank;
      end
      // Active image only changes between frames so a frame is never torn.
      if (boundary && pending) begin
        act_data  <= sh_data;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        pending   <= 1'b0;
      end else if (accept) begin
        pending <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h01;
      4'h1: hex7 = 7'h4F;
      4'h2: hex7 = 7'h12;
      4'h3: hex7 = 7'h06;
      4'h4: hex7 = 7'h4C;
      4'h5: hex7 = 7'h24;
      4'h6: hex7 = 7'h20;
      4'h7: hex7 = 7'h0F;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h04;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h60;
      4'hC: hex7 = 7'h31;
      4'hD: hex7 = 7'h42;
      4'hE: hex7 = 7'h30;
      default: hex7 = 7'h38;
    endcase
  endfunction

  logic [3:0]        cur_nib;
  logic              cur_dp, cur_blank, cur_lz;
  logic [DIGITS-1:0] lz;

`ifdef LEDSCAN_LZS_EN
  // A digit is suppressed while it and everything above it is zero with no dp.
  always_comb begin
    logic keep;
    keep = 1'b0;
    lz   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      keep  = keep | (act_data[4*i +: 4] != 4'h0) | act_dp[i];
      lz[i] = !keep && (i != 0);
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = act_data[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = act_blank[i];
        cur_lz    = lz[i];
      end
    end
  end

  assign sel = DIGITS'(1) << idx;
  assign seg = (cur_blank || cur_lz) ? 8'hFF : {~cur_dp, hex7(cur_nib)};

endmodule
